// File: rtl/pcileech_vmd_msix_irq_gen_pkg.sv
// pcileech_msix_pkg: shared types, TLP constants and helpers for the VMD MSI-X interrupt generator.
package pcileech_msix_pkg;

   localparam logic [31:0] MWR32_DW0     = 32'h4000_0001;
   localparam logic [31:0] MWR64_DW0     = 32'h6000_0001;
   localparam logic [7:0]  FIRST_BE_FULL = 8'h0F;

   typedef struct packed {
      logic [31:0] addr_lo;
      logic [31:0] addr_hi;
      logic [31:0] data;
      logic        mask;
   } msix_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_BEAT3DW,
      ST_BEAT4DW_0,
      ST_BEAT4DW_1
   } msix_state_t;

   function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
      return {be[3] ? new_w[31:24] : old_w[31:24],
              be[2] ? new_w[23:16] : old_w[23:16],
              be[1] ? new_w[15:8]  : old_w[15:8],
              be[0] ? new_w[7:0]   : old_w[7:0]};
   endfunction

endpackage

// File: rtl/pcileech_vmd_msix_irq_gen_if.sv
// pcileech_vmd_msix_irq_gen_if: bundle of the table/PBA access, interrupt request and TX TLP stream signals.
// master = VMD BAR / TX mux side, slave = interrupt generator.
interface pcileech_vmd_msix_irq_gen_if #(
   parameter int VECTORS = 8
);
   localparam int AW = $clog2(VECTORS) + 2;

   logic [15:0]        pcie_id;
   logic               msix_enable;
   logic               msix_func_mask;
   logic [VECTORS-1:0] irq_req;
   logic               tbl_wr_valid;
   logic [AW-1:0]      tbl_addr;
   logic [31:0]        tbl_wr_data;
   logic [3:0]         tbl_wr_be;
   logic [31:0]        tbl_rd_data;
   logic [31:0]        pba_rd_data;
   logic [127:0]       tx_tdata;
   logic [3:0]         tx_tkeepdw;
   logic               tx_tvalid;
   logic               tx_tlast;
   logic               tx_tready;
   logic [15:0]        irq_sent_cnt;
   logic [15:0]        irq_err_cnt;

   modport master (
      output pcie_id, msix_enable, msix_func_mask, irq_req,
             tbl_wr_valid, tbl_addr, tbl_wr_data, tbl_wr_be, tx_tready,
      input  tbl_rd_data, pba_rd_data, tx_tdata, tx_tkeepdw, tx_tvalid, tx_tlast,
             irq_sent_cnt, irq_err_cnt
   );

   modport slave (
      input  pcie_id, msix_enable, msix_func_mask, irq_req,
             tbl_wr_valid, tbl_addr, tbl_wr_data, tbl_wr_be, tx_tready,
      output tbl_rd_data, pba_rd_data, tx_tdata, tx_tkeepdw, tx_tvalid, tx_tlast,
             irq_sent_cnt, irq_err_cnt
   );

endinterface

// File: rtl/pcileech_vmd_msix_irq_gen_rr_arbiter.sv
// pcileech_msix_rr_arbiter: combinational round-robin pick starting at i_last+1.
// i_req: request vector, i_last: previously granted index, o_grant: picked index, o_valid: any request.
module pcileech_msix_rr_arbiter #(
   parameter int VECTORS = 8,
   localparam int IW = (VECTORS > 1) ? $clog2(VECTORS) : 1
)(
   input  logic [VECTORS-1:0] i_req,
   input  logic [IW-1:0]      i_last,
   output logic [IW-1:0]      o_grant,
   output logic               o_valid
);
   localparam int N = 1 << IW;

   logic [N-1:0] w_req;

   assign w_req   = N'(i_req);
   assign o_valid = |i_req;

   // Scan from the farthest offset down so the nearest requester after i_last wins.
   always_comb begin
      o_grant = i_last;
      for (int i = N; i >= 1; i--)
         if (w_req[i_last + IW'(i)]) o_grant = i_last + IW'(i);
   end

endmodule

// File: rtl/pcileech_vmd_msix_irq_gen.sv
// pcileech_vmd_msix_irq_gen: MSI-X vector table, PBA and posted MWr TLP generator for the VMD BAR path.
// clk_pcie/rst: PCIe user clock, sync active-high reset.
// bus (slave): table write/read, PBA read, irq_req pulses, 128-bit TX TLP stream, sent/error counters.
// Optional PCILEECH_MSIX_RATE_LIMIT_EN adds RATE_GAP idle cycles after each completed TLP.
module pcileech_vmd_msix_irq_gen
   import pcileech_msix_pkg::*;
#(
   parameter int         VECTORS  = 8,
   parameter logic [7:0] TAG_INIT = 8'h00
`ifdef PCILEECH_MSIX_RATE_LIMIT_EN
   , parameter int       RATE_GAP = 64
`endif
)(
   input logic                         clk_pcie,
   input logic                         rst,
   pcileech_vmd_msix_irq_gen_if.slave  bus
);
   localparam int IW = (VECTORS > 1) ? $clog2(VECTORS) : 1;

   msix_entry_t        r_tbl [VECTORS];
   msix_state_t        r_state;
   logic [VECTORS-1:0] r_pba;
   logic [IW-1:0]      r_last;
   logic [IW-1:0]      r_vec;
   logic [31:0]        r_data;
   logic [31:0]        r_rd;
   logic [7:0]         r_tag;
   logic [15:0]        r_sent;
   logic [15:0]        r_err;
   logic [127:0]       r_tdata;
   logic [3:0]         r_keep;
   logic               r_tvalid;
   logic               r_tlast;

   msix_entry_t        w_cur;
   msix_entry_t        w_wr;
   msix_entry_t        w_pick;
   logic [VECTORS-1:0] w_mask;
   logic [VECTORS-1:0] w_elig;
   logic [VECTORS-1:0] w_clr;
   logic [IW-1:0]      w_ent;
   logic [IW-1:0]      w_grant;
   logic [1:0]         w_word;
   logic [31:0]        w_hdr;
   logic               w_gvalid;
   logic               w_done;
   logic               w_bad;
   logic               w_go;

   assign w_ent  = IW'(bus.tbl_addr >> 2);
   assign w_word = bus.tbl_addr[1:0];
   assign w_cur  = r_tbl[w_ent];
   assign w_pick = r_tbl[w_grant];
   assign w_hdr  = {bus.pcie_id, r_tag, FIRST_BE_FULL};
   assign w_done = r_tvalid & r_tlast & bus.tx_tready;
   assign w_bad  = (r_state == ST_SELECT) & w_gvalid & (w_pick.addr_lo[1:0] != 2'b00);
   assign w_clr  = (w_done ? VECTORS'(1) << r_vec : '0) | (w_bad ? VECTORS'(1) << w_grant : '0);
   assign w_elig = r_pba & ~w_mask & {VECTORS{bus.msix_enable & ~bus.msix_func_mask}};

   always_comb begin
      w_mask = '0;
      for (int v = 0; v < VECTORS; v++) w_mask[v] = r_tbl[v].mask;
   end

   // Byte-enable merge into the addressed word; only bit0 of vector control exists.
   always_comb begin
      w_wr         = w_cur;
      w_wr.addr_lo = (w_word == 2'd0) ? be_merge(w_cur.addr_lo, bus.tbl_wr_data, bus.tbl_wr_be) : w_cur.addr_lo;
      w_wr.addr_hi = (w_word == 2'd1) ? be_merge(w_cur.addr_hi, bus.tbl_wr_data, bus.tbl_wr_be) : w_cur.addr_hi;
      w_wr.data    = (w_word == 2'd2) ? be_merge(w_cur.data, bus.tbl_wr_data, bus.tbl_wr_be) : w_cur.data;
      w_wr.mask    = (w_word == 2'd3 && bus.tbl_wr_be[0]) ? bus.tbl_wr_data[0] : w_cur.mask;
   end

   pcileech_msix_rr_arbiter #(.VECTORS(VECTORS)) u_arb (
      .i_req   (w_elig),
      .i_last  (r_last),
      .o_grant (w_grant),
      .o_valid (w_gvalid)
   );

`ifdef PCILEECH_MSIX_RATE_LIMIT_EN
   logic [15:0] r_gap;
   always_ff @(posedge clk_pcie) begin
      if (rst) r_gap <= '0;
      else     r_gap <= w_done ? 16'(RATE_GAP) : (r_gap != 16'd0) ? r_gap - 16'd1 : r_gap;
   end
   assign w_go = (r_gap == 16'd0);
`else
   assign w_go = 1'b1;
`endif

   // Table and PBA. A request landing with its own clear wins, so the vector is re-sent.
   always_ff @(posedge clk_pcie) begin
      if (rst) begin
         for (int i = 0; i < VECTORS; i++)
            r_tbl[i] <= '{addr_lo: 32'h0, addr_hi: 32'h0, data: 32'h0, mask: 1'b1};
         r_pba <= '0;
         r_rd  <= '0;
      end else begin
         r_pba <= (r_pba & ~w_clr) | bus.irq_req;
         if (bus.tbl_wr_valid) r_tbl[w_ent] <= w_wr;
         r_rd  <= (w_word == 2'd0) ? w_cur.addr_lo :
                  (w_word == 2'd1) ? w_cur.addr_hi :
                  (w_word == 2'd2) ? w_cur.data    : {31'h0, w_cur.mask};
      end
   end

   // TLP FSM. Beat contents are captured in SELECT so later table writes or
   // mask/enable changes cannot disturb a packet already on the stream.
   always_ff @(posedge clk_pcie) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tdata  <= '0;
         r_keep   <= '0;
         r_tag    <= TAG_INIT;
         r_sent   <= '0;
         r_err    <= '0;
         r_last   <= IW'(VECTORS - 1);
         r_vec    <= '0;
         r_data   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (|w_elig && w_go) r_state <= ST_SELECT;
            ST_SELECT: begin
               if (!w_gvalid) r_state <= ST_IDLE;
               else if (w_bad) begin
                  r_err   <= r_err + {15'h0, ~&r_err};
                  r_state <= ST_IDLE;
               end else begin
                  r_vec    <= w_grant;
                  r_data   <= w_pick.data;
                  r_tvalid <= 1'b1;
                  r_keep   <= 4'hF;
                  if (w_pick.addr_hi == 32'h0) begin
                     r_state <= ST_BEAT3DW;
                     r_tlast <= 1'b1;
                     r_tdata <= {w_pick.data, w_pick.addr_lo[31:2], 2'b00, w_hdr, MWR32_DW0};
                  end else begin
                     r_state <= ST_BEAT4DW_0;
                     r_tlast <= 1'b0;
                     r_tdata <= {w_pick.addr_lo, w_pick.addr_hi, w_hdr, MWR64_DW0};
                  end
               end
            end
            ST_BEAT4DW_0: if (bus.tx_tready) begin
               r_state <= ST_BEAT4DW_1;
               r_tdata <= {96'h0, r_data};
               r_keep  <= 4'h1;
               r_tlast <= 1'b1;
            end
            ST_BEAT3DW, ST_BEAT4DW_1: if (w_done) begin
               r_state  <= ST_IDLE;
               r_tvalid <= 1'b0;
               r_tlast  <= 1'b0;
               r_tdata  <= '0;
               r_keep   <= '0;
               r_tag    <= r_tag + 8'd1;
               r_sent   <= r_sent + {15'h0, ~&r_sent};
               r_last   <= r_vec;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.tbl_rd_data  = r_rd;
   assign bus.pba_rd_data  = 32'(r_pba);
   assign bus.tx_tdata     = r_tdata;
   assign bus.tx_tkeepdw   = r_keep;
   assign bus.tx_tvalid    = r_tvalid;
   assign bus.tx_tlast     = r_tlast;
   assign bus.irq_sent_cnt = r_sent;
   assign bus.irq_err_cnt  = r_err;

endmodule

// File: doc/pcileech_vmd_msix_irq_gen.md
Name: pcileech_vmd_msix_irq_gen

Overview:
- Interrupt back-end of the VMD BAR path. Holds the MSI-X vector table and the Pending Bit Array (PBA).
- Upstream, the VMD BAR implementation forwards MSI-X table and PBA accesses and raises per-vector interrupt requests.
- Downstream, the block emits posted Memory-Write TLPs (128-bit AXI-stream) into a spare source port of the TX TLP mux.
- Single clock domain (PCIe user clock).

Parameters:
- VECTORS, 8: number of MSI-X vectors, power of two, 1..32.
- TAG_INIT, 8'h00: reset value of the TLP tag counter.

Ports:
- clk_pcie, in, 1: PCIe user clock.
- rst, in, 1: synchronous reset, active-high.
- pcie_id, in, 16: requester ID {bus, dev, func} placed in the header.
- msix_enable, in, 1: MSI-X Enable bit from the capability.
- msix_func_mask, in, 1: Function Mask bit from the capability.
- irq_req, in, VECTORS: one-cycle request pulse per vector.
- tbl_wr_valid, in, 1: table write strobe.
- tbl_addr, in, $clog2(VECTORS)+2: dword index into the table (entry = addr[MSB:2], word = addr[1:0]).
- tbl_wr_data, in, 32: write data.
- tbl_wr_be, in, 4: write byte enables.
- tbl_rd_data, out, 32: registered read of tbl_addr, 1-cycle latency.
- pba_rd_data, out, 32: registered PBA, zero-extended.
- tx_tdata, out, 128: TLP data, DW0 in bits [31:0].
- tx_tkeepdw, out, 4: valid dwords.
- tx_tvalid, out, 1: stream valid.
- tx_tlast, out, 1: last beat of TLP.
- tx_tready, in, 1: stream ready.
- irq_sent_cnt, out, 16: count of TLPs completed.
- irq_err_cnt, out, 16: count of vectors dropped for a bad address.

Behaviour:
- Reset values:
  - Every vector-control word = 1 (masked). Address and data words = 0. PBA = 0.
  - tx_tvalid = 0, tx_tlast = 0, tx_tdata = 0, tx_tkeepdw = 0.
  - tbl_rd_data = 0. Both counters = 0. Tag = TAG_INIT. FSM state = IDLE.
- Table entry layout: word0 addr_lo, word1 addr_hi, word2 data, word3 vector control (only bit0 implemented, others read 0). Writes honour byte enables.
- Pending set: irq_req[v] sets pba[v] on the next edge, whatever the mask state.
- Same-cycle set and clear: if irq_req[v] and the clear of pba[v] land in the same cycle, pba[v] stays 1 and v is re-sent later.
- Eligibility: eligible[v] = pba[v] & ~mask[v] & msix_enable & ~msix_func_mask.
- FSM states:
  - IDLE: if any vector is eligible, go to SELECT.
  - SELECT (1 cycle): round-robin pick starting at last_granted+1, modulo VECTORS. Snapshot addr_lo, addr_hi and data of the picked entry.
    - If snapshot addr_lo[1:0] != 0: clear pba, increment irq_err_cnt, return to IDLE.
    - Else if addr_hi == 0: go to BEAT3DW.
    - Else: go to BEAT4DW_0.
  - BEAT3DW: tdata = {data, addr_lo[31:2]<<2, {pcie_id, tag, 8'h0F}, 32'h4000_0001}; tkeepdw = 4'hF; tlast = 1.
  - BEAT4DW_0: tdata = {addr_lo, addr_hi, {pcie_id, tag, 8'h0F}, 32'h6000_0001}; tkeepdw = 4'hF; tlast = 0. On tready go to BEAT4DW_1.
  - BEAT4DW_1: tdata[31:0] = data, all other bits 0; tkeepdw = 4'h1; tlast = 1.
  - On the last-beat handshake: clear pba[v], tag++ (8-bit wrap), irq_sent_cnt++ (saturates at 16'hFFFF), last_granted = v, go to IDLE.
- AXI-stream rules: once tvalid is asserted, tdata, tkeepdw and tlast hold until tready. The packet always completes even if msix_enable, the function mask or the vector mask changes mid-packet.
- Latency: irq_req edge to first tvalid = 3 cycles with tready held high.
- Snapshot consistency: table writes during SELECT or a BEAT state affect only later TLPs.
- Masking: a masked pending vector stays in the PBA. Unmasking it yields a TLP.
- Reset mid-packet: tvalid = 0 on the next cycle; the partial packet is abandoned.

Optional Feature:
- Macro: PCILEECH_MSIX_RATE_LIMIT_EN.
- When defined: adds parameter RATE_GAP (default 64). After each completed TLP, IDLE will not enter SELECT until a 16-bit down-counter loaded with RATE_GAP reaches 0. Pending bits keep accumulating meanwhile.
- When undefined: no counter; IDLE enters SELECT immediately.

Decomposition:
- Package pcileech_msix_pkg holds:
  - typedef msix_entry_t {addr_lo, addr_hi, data, mask}.
  - Constants MWR32_DW0 = 32'h4000_0001, MWR64_DW0 = 32'h6000_0001, FIRST_BE_FULL = 8'h0F.
  - FSM state enum.
- Sub-module pcileech_msix_rr_arbiter: combinational round-robin pick over a VECTORS-wide request vector given last_granted. Outputs grant index and a valid flag.

Test Plan:
- Write entry 2 = {addr_lo 32'hFEE0_0000, addr_hi 0, data 32'h0000_0041, ctrl 0}, enable set, pulse irq_req[2] -> one beat, tdata = {32'h41, 32'hFEE0_0000, {pcie_id, 8'h00, 8'h0F}, 32'h4000_0001}, tkeepdw F, tlast 1; pba[2] clears; irq_sent_cnt = 1.
- Entry 5 with addr_hi 32'h1, addr_lo 32'h2000_0000, tready low for 4 cycles -> beat0 held stable throughout; beat1 tkeepdw 1, tdata[31:0] = data; tag = 01.
- Vector 3 masked, pulse irq_req[3] -> no TLP, pba_rd_data = 32'h8; clear the mask -> TLP emitted, pba = 0.
- Pulse vectors 1, 4, 6 in the same cycle -> TLPs in order 1, 4, 6; then pulse 1 and 6 -> order 6? No: with last_granted = 6 the next order is 1, then 6.
- addr_lo = 32'hFEE0_0002 -> no TLP, irq_err_cnt = 1, pba bit cleared.
- Assert rst during BEAT4DW_0 -> next cycle tvalid = 0, pba = 0, all entries masked.
